// File: rtl/fsm_seq_arb.sv
// fsm_seq_arb: grants one of two requesters, runs its pattern LSB-first through a shared serial FSM, returns the y bits.
// Define FSM_SEQ_ARB_RR_EN for round-robin tie-break; default build is fixed priority to requester 0.
module fsm_seq_arb #(
  parameter int PAT_W = 8,
  localparam int LEN_W = (PAT_W > 1) ? $clog2(PAT_W) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [PAT_W-1:0] req0_pattern,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [PAT_W-1:0] req1_pattern,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  output logic             fsm_reset,
  output logic             fsm_x,
  input  logic             fsm_y,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [PAT_W-1:0] rsp_y,
  input  logic             rsp_ready,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CLR  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] rsp_y_q, rsp_y_d;
  logic             id_q, id_d;
  logic             gnt_id;
  logic             accept;

`ifdef FSM_SEQ_ARB_RR_EN
  // last_q resets to 1 so requester 0 wins the first tie.
  logic last_q, last_d;

  always_comb begin
    gnt_id = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    last_d = accept ? gnt_id : last_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'b1;
    else          last_q <= last_d;
  end
`else
  always_comb begin
    gnt_id = req1_valid && !req0_valid;
  end
`endif

  always_comb begin
    accept     = (state_q == S_IDLE) && reset_n && (gnt_id ? req1_valid : req0_valid);
    req0_ready = accept && !gnt_id;
    req1_ready = accept && gnt_id;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    pat_d   = pat_q;
    id_d    = id_q;
    rsp_y_d = rsp_y_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          pat_d   = gnt_id ? req1_pattern : req0_pattern;
          len_d   = gnt_id ? req1_len : req0_len;
          id_d    = gnt_id;
          rsp_y_d = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        rsp_y_d[cnt_q] = fsm_y;
        // Stop on the last bit rather than incrementing, so cnt never wraps at PAT_W-1.
        if (cnt_q == len_q) state_d = S_RESP;
        else                cnt_d   = cnt_q + 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      pat_q   <= '0;
      id_q    <= 1'b0;
      rsp_y_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      id_q    <= id_d;
      rsp_y_q <= rsp_y_d;
    end
  end

  // The shared FSM must be held in reset together with this block.
  always_comb begin
    fsm_reset = !reset_n || (state_q == S_CLR);
    fsm_x     = (state_q == S_RUN) && pat_q[cnt_q];
    rsp_valid = (state_q == S_RESP);
    rsp_id    = id_q;
    rsp_y     = rsp_y_q;
    busy      = (state_q != S_IDLE);
  end

endmodule
